// File: rtl/gate74_piso_tx_if.sv
// Bus bundle for the gate74 PISO transmitter.
// The master side drives the load request and parallel word.
// The slave side (the transmitter) returns the complementary serial pair and the frame status.
interface gate74_piso_tx_if #(
  parameter int WIDTH = 8
);
  logic             LD;
  logic [WIDTH-1:0] DIN;
  logic             SDO;
  logic             SDOn;
  logic             BUSY;
  logic             DONE;

  modport master (
    output LD,
    output DIN,
    input  SDO,
    input  SDOn,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  LD,
    input  DIN,
    output SDO,
    output SDOn,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/gate74_piso_tx.sv
// gate74_piso_tx: parallel-in, serial-out frame transmitter.
// Each frame is a start bit (0), WIDTH data bits sent LSB first, and a stop bit (1).
// Every bit is held for DIV clocks.
// SDO and SDOn are the Q/Qn pair of a single register.
// Optional macro GATE74_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module gate74_piso_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  gate74_piso_tx_if.slave   bus
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef GATE74_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shNext;
  logic [4:0]       bitcnt;
  logic [DW-1:0]    divcnt;
  logic             tick;
  logic             sdo;
  logic             busy;
  logic             done;
`ifdef GATE74_TX_PARITY_EN
  logic             parity;
`endif

  // Terminal count of the bit-period divider, and the shift register after one more bit has been sent.
  assign tick   = (divcnt == DW'(DIV - 1));
  assign shNext = shreg >> 1;

  // SDOn comes from the same flop as SDO, so the pair can never be equal.
  assign bus.SDO  = sdo;
  assign bus.SDOn = ~sdo;
  assign bus.BUSY = busy;
  assign bus.DONE = done;

  // Frame sequencer.
  // The divider paces each bit period, the bit counter tracks data bits, and all outputs are registered.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
      sdo    <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef GATE74_TX_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sdo    <= 1'b1;
          busy   <= 1'b0;
          divcnt <= '0;
          if (bus.LD) begin
            shreg  <= bus.DIN;
`ifdef GATE74_TX_PARITY_EN
            parity <= ^bus.DIN;
`endif
            state  <= START;
            sdo    <= 1'b0;
            busy   <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            divcnt <= '0;
            bitcnt <= '0;
            state  <= DATA;
            sdo    <= shreg[0];
          end else begin
            divcnt <= divcnt + DW'(1);
          end
        end

        DATA: begin
          if (tick) begin
            divcnt <= '0;
            shreg  <= shNext;
            if (bitcnt == 5'(WIDTH - 1)) begin
`ifdef GATE74_TX_PARITY_EN
              state <= PARITY;
              sdo   <= parity;
`else
              state <= STOP;
              sdo   <= 1'b1;
`endif
            end else begin
              bitcnt <= bitcnt + 5'd1;
              sdo    <= shNext[0];
            end
          end else begin
            divcnt <= divcnt + DW'(1);
          end
        end

`ifdef GATE74_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            divcnt <= '0;
            state  <= STOP;
            sdo    <= 1'b1;
          end else begin
            divcnt <= divcnt + DW'(1);
          end
        end
`endif

        STOP: begin
          if (tick) begin
            divcnt <= '0;
            state  <= IDLE;
            sdo    <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            divcnt <= divcnt + DW'(1);
          end
        end

        default: begin
          state <= IDLE;
          sdo   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate74_piso_tx.sv
// Testbench for gate74_piso_tx (WIDTH=8, DIV=4).
// Stimulus pushes hand-computed frames into a queue, and a negedge monitor pops and compares one frame per DONE pulse.
module tb_gate74_piso_tx;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;

`ifdef GATE74_TX_PARITY_EN
  localparam int          FB       = WIDTH + 3;
  localparam logic [15:0] FRAME_A5 = 16'b101_0100_1010;
  localparam logic [15:0] FRAME_07 = 16'b110_0000_1110;
  localparam logic [15:0] FRAME_01 = 16'b110_0000_0010;
  localparam logic [15:0] FRAME_FF = 16'b101_1111_1110;
`else
  localparam int          FB       = WIDTH + 2;
  localparam logic [15:0] FRAME_A5 = 16'b11_0100_1010;
  localparam logic [15:0] FRAME_07 = 16'b10_0000_1110;
  localparam logic [15:0] FRAME_01 = 16'b10_0000_0010;
  localparam logic [15:0] FRAME_FF = 16'b11_1111_1110;
`endif

  typedef struct {
    logic [15:0] bits;
    bit          b2b;
  } exp_t;

  logic CLK;
  logic CLR;
  gate74_piso_tx_if #(.WIDTH(WIDTH)) bus ();

  gate74_piso_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  exp_t expQ[$];
  int   checks     = 0;
  int   failures   = 0;
  int   doneCount  = 0;
  int   cycle      = 0;
  int   lastDone   = -100;
  bit   capturing  = 0;
  bit   prevBusy   = 0;
  bit   prevDone   = 0;
  bit   sdonOk     = 1;
  int   cnt        = 0;
  logic samp [0:255];

  // Free-running clock with a 10-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compares one value against its expected value and records the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Requests one load: LD is high for exactly one rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] din);
    @(negedge CLK);
    bus.LD  = 1'b1;
    bus.DIN = din;
    @(negedge CLK);
    bus.LD  = 1'b0;
  endtask

  // Waits, with a cycle bound, until DONE is seen on a negedge.
  task automatic waitDone(input int maxCycles);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.DONE && n < maxCycles);
    if (!bus.DONE) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout actual=no DONE expected=DONE within %0d cycles", maxCycles);
    end
  endtask

  // Monitor: records SDO for every BUSY cycle and scores the frame against the queue head on the DONE cycle.
  always @(negedge CLK) begin
    cycle++;
    if (bus.DONE && prevDone) checkOutput("done_one_cycle", 32'(bus.DONE & prevDone), 32'd0);
    if (bus.BUSY && !prevBusy) begin
      capturing = 1;
      cnt       = 0;
      sdonOk    = 1;
      if (expQ.size() > 0 && expQ[0].b2b)
        checkOutput("b2b_gap", 32'(cycle - lastDone), 32'd1);
    end
    if (capturing && bus.BUSY) begin
      if (cnt < 256) samp[cnt] = bus.SDO;
      if (bus.SDOn === bus.SDO) sdonOk = 0;
      cnt++;
    end
    if (capturing && !bus.BUSY) begin
      capturing = 0;
      if (bus.DONE) begin
        logic [15:0] obs;
        bit          held;
        exp_t        e;
        lastDone = cycle;
        doneCount++;
        obs  = '0;
        held = 1;
        for (int k = 0; k < FB; k++) obs[k] = samp[k * DIV];
        for (int i = 0; i < cnt && i < 256; i++)
          if (samp[i] !== samp[(i / DIV) * DIV]) held = 0;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'(doneCount), 32'(doneCount - 1));
        end else begin
          e = expQ.pop_front();
          checkOutput("busy_cycles", 32'(cnt), 32'(FB * DIV));
          checkOutput("frame_bits", 32'(obs), 32'(e.bits));
          checkOutput("bit_held_div", 32'(held), 32'd1);
          checkOutput("sdon_complement", 32'(sdonOk), 32'd1);
          checkOutput("idle_sdo_high", 32'(bus.SDO), 32'd1);
        end
      end
    end
    prevBusy = bus.BUSY;
    prevDone = bus.DONE;
  end

  // Directed sequence: reset, single frame with ignored load, back-to-back, parity vector, mid-frame reset.
  initial begin
    CLR     = 1'b0;
    bus.LD  = 1'b0;
    bus.DIN = '0;
    #1 CLR = 1'b1;
    #1;
    checkOutput("reset_sdo", 32'(bus.SDO), 32'd1);
    checkOutput("reset_sdon", 32'(bus.SDOn), 32'd0);
    checkOutput("reset_busy", 32'(bus.BUSY), 32'd0);
    checkOutput("reset_done", 32'(bus.DONE), 32'd0);
    repeat (2) @(negedge CLK);
    CLR = 1'b0;
    repeat (10) @(negedge CLK);
    checkOutput("idle_sdo", 32'(bus.SDO), 32'd1);
    checkOutput("idle_sdon", 32'(bus.SDOn), 32'd0);
    checkOutput("idle_busy", 32'(bus.BUSY), 32'd0);
    checkOutput("idle_done", 32'(bus.DONE), 32'd0);

    expQ.push_back('{FRAME_A5, 1'b0});
    applyStimulus(8'hA5);
    repeat (10) @(negedge CLK);
    bus.LD  = 1'b1;
    bus.DIN = 8'h3C;
    @(negedge CLK);
    bus.LD  = 1'b0;
    waitDone(200);
    repeat (3) @(negedge CLK);

    expQ.push_back('{FRAME_01, 1'b0});
    expQ.push_back('{FRAME_FF, 1'b1});
    @(negedge CLK);
    bus.LD  = 1'b1;
    bus.DIN = 8'h01;
    @(negedge CLK);
    bus.DIN = 8'hFF;
    waitDone(200);
    @(negedge CLK);
    bus.LD  = 1'b0;
    waitDone(200);
    repeat (3) @(negedge CLK);

    expQ.push_back('{FRAME_07, 1'b0});
    applyStimulus(8'h07);
    waitDone(200);
    repeat (3) @(negedge CLK);

    applyStimulus(8'hA5);
    repeat (19) @(negedge CLK);
    #2 CLR = 1'b1;
    #1;
    checkOutput("midreset_sdo", 32'(bus.SDO), 32'd1);
    checkOutput("midreset_sdon", 32'(bus.SDOn), 32'd0);
    checkOutput("midreset_busy", 32'(bus.BUSY), 32'd0);
    checkOutput("midreset_done", 32'(bus.DONE), 32'd0);
    @(negedge CLK);
    #2 CLR = 1'b0;
    repeat (3) @(negedge CLK);
    expQ.push_back('{FRAME_A5, 1'b0});
    applyStimulus(8'hA5);
    waitDone(200);
    repeat (5) @(negedge CLK);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("done_pulses", 32'(doneCount), 32'd5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate74_piso_tx.md
Name: gate74_piso_tx

Overview:
- Parallel-in, serial-out frame transmitter in the 74-series model library. It is the driving end for serial receivers built from D-flip-flop and shift-register chip models.
- A parallel word is loaded on request. The block sends it on one serial line, framed as: start bit (0), WIDTH data bits LSB first, stop bit (1).
- Each bit is held for DIV clocks.
- Outputs are complementary (SDO/SDOn), matching the Q/Qn convention of the flop models.

Parameters:
- WIDTH, 8, data word width in bits; legal range 1..16.
- DIV, 4, clocks per serial bit period; legal range 1..256.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- CLR  input  1  reset; asynchronous, active-high (CLR=1 resets immediately, with no clock needed).
- LD  input  1  load request; sampled on posedge CLK.
- DIN  input  WIDTH  parallel data; captured on the edge where the load is accepted.
- SDO  output  1  serial data out; idles high.
- SDOn  output  1  always ~SDO.
- BUSY  output  1  high while a frame is in progress.
- DONE  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- All outputs are registered.
- Reset values: SDO=1, SDOn=0, BUSY=0, DONE=0. State=IDLE; shift register, bit counter and divider counter are all 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - SDO=1, BUSY=0.
  - On a posedge with LD=1: capture DIN, then go to START.
  - In the cycle after that edge: SDO=0, BUSY=1.
- Divider: counts 0..DIV-1. Each bit is held exactly DIV clocks, and the divider advances the bit on its terminal count.
- START: SDO=0 for DIV clocks, then go to DATA with the bit counter = 0.
- DATA:
  - SDO = shreg[0]; on each bit boundary, shreg shifts right.
  - After WIDTH bits, go to STOP.
  - The bit counter is wide enough for WIDTH=16 and does not wrap before WIDTH.
- STOP: SDO=1 for DIV clocks, then return to IDLE.
- Return to IDLE: in the first IDLE cycle, BUSY=0 and DONE=1 for exactly one cycle.
- BUSY high time: exactly (WIDTH+2)*DIV consecutive cycles per frame.
- LD while BUSY=1 is ignored. Nothing is queued and DIN is not re-sampled, so changing DIN mid-frame has no effect.
- LD=1 in the DONE cycle is accepted. The result is back-to-back frames with one idle-high cycle between stop and start.
- LD held high continuously: each frame starts on the first IDLE cycle, giving a period of (WIDTH+2)*DIV+1 cycles.
- DIV=1: each bit lasts one clock; all transitions are still as above.
- CLR asserted mid-frame: immediate return to reset values. SDO goes high, no DONE pulse is produced, and the partial frame is discarded.
- CLR released: the block is in IDLE. The first posedge after release may accept LD.
- SDOn is derived from the same register as SDO, so the two are never equal, even for a delta cycle.

Optional Feature:
- Macro: GATE74_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all captured data bits) is inserted between the last data bit and the stop bit.
  - The parity bit is held DIV clocks, using an extra PARITY state.
  - BUSY high time becomes (WIDTH+3)*DIV.
- Undefined: no parity state or logic exists, and framing is exactly as in Behaviour.

Test Plan:
- Reset: CLR=1 with no clock edges -> SDO=1, SDOn=0, BUSY=0, DONE=0 immediately. Release CLR with LD=0 for 10 clocks -> outputs unchanged.
- Single frame, WIDTH=8, DIV=4, DIN=8'hA5, LD pulsed 1 cycle:
  - SDO sequence, each level for 4 clocks: 0, 1,0,1,0,0,1,0,1, 1.
  - BUSY high for 40 cycles; DONE high on cycle 41 only.
  - SDOn = ~SDO throughout.
- Ignored load: during the frame for 8'hA5, pulse LD with DIN=8'h3C at cycle 12 -> the transmitted bits are still those of 8'hA5, and there is exactly one DONE pulse.
- Back-to-back: LD held high, DIN=8'h01 then 8'hFF -> second start bit begins exactly 1 idle-high cycle after the first stop bit ends; second frame data bits are all 1.
- Mid-frame reset: assert CLR at cycle 20 of an 8'hA5 frame -> SDO=1 and BUSY=0 immediately, no DONE. A new LD after release sends a full, correct frame.
- GATE74_TX_PARITY_EN defined, DIN=8'hA5 (four ones) -> parity bit 0 before the stop bit, BUSY=44 cycles. DIN=8'h07 -> parity bit 1.
